interval_timer: RTL
===================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter: DATA_WIDTH, 16, width of bus_in, count and the load value.
REQ-002 Parameter: PRESCALE, 4, clock edges per count decrement; legal range 1..256.
REQ-003 Port: clk  input  1  system clock, all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high.
REQ-005 Port: bus_in  input  DATA_WIDTH  internal data bus, sampled as load value.
REQ-006 Port: timer_in  input  1  load strobe from control unit (single-cycle, privileged timer-write instruction).
REQ-007 Port: privileged  input  1  PSW privileged bit; 1 = supervisor, timer frozen.
REQ-008 Port: timeout  output  1  registered; 1 = quantum expired, consumed by control unit at instruction end.
REQ-009 Port: running  output  1  registered; 1 = state RUN.
REQ-010 Port: count  output  DATA_WIDTH  current remaining count, for debug/observation.

Function
REQ-011 The block SHALL implement three states: IDLE (disarmed), RUN (counting), EXPIRED (timeout held).
REQ-012 The block SHALL hold an internal prescaler counter pre, range 0..PRESCALE-1, 8 bits.
REQ-013 timer_in=1 with bus_in=V, V!=0, SHALL set count<=V, pre<=0, state<=RUN, in any state.
REQ-014 timer_in=1 with bus_in=0 SHALL set count<=0, pre<=0, state<=IDLE (disarm), in any state.
REQ-015 timer_in SHALL have priority over every decrement, prescaler step and expiry on the same edge.
REQ-016 RUN, privileged=1, timer_in=0: count and pre SHALL hold (paused); no expiry.
REQ-017 RUN, privileged=0, timer_in=0, pre!=PRESCALE-1: pre<=pre+1, count holds.
REQ-018 RUN, privileged=0, timer_in=0, pre==PRESCALE-1: pre<=0, count<=count-1.
REQ-019 When the REQ-018 decrement takes count from 1 to 0, state SHALL move to EXPIRED on that same edge.
REQ-020 With PRESCALE=1, pre SHALL stay 0 and count SHALL decrement on every unprivileged RUN edge.
REQ-021 Load-to-timeout latency SHALL be exactly V*PRESCALE unprivileged edges after the load edge; privileged edges do not count.
REQ-022 EXPIRED SHALL persist, count=0, regardless of privileged, until timer_in or reset.
REQ-023 IDLE SHALL ignore privileged; count and pre hold at 0.
REQ-024 timeout SHALL equal (state==EXPIRED), running SHALL equal (state==RUN), both registered, no combinational path from any input.
REQ-025 count SHALL never wrap below 0; no decrement occurs outside RUN.
REQ-026 Any unencoded state SHALL recover to IDLE on the next edge with count<=0, pre<=0.

Reset
REQ-027 reset=1 SHALL asynchronously force state=IDLE, count=0, pre=0, timeout=0, running=0.
REQ-028 Reset during RUN or EXPIRED SHALL discard the remaining count; timer stays IDLE until the next timer_in load after reset release.
REQ-029 timer_in asserted while reset=1 SHALL be ignored.

Verification (PRESCALE=4 unless stated)
REQ-030 Load bus_in=3, privileged=0 held -> count 3,2,1,0 at edges 4,8,12 after load; timeout=1 after edge 12, running=0.
REQ-031 Load 5, privileged=0 for 6 edges, privileged=1 for 20 edges, then privileged=0 -> count=4 throughout pause; timeout after 14 further unprivileged edges.
REQ-032 In EXPIRED, load bus_in=0x0010 -> timeout=0, running=1, count=16 after that edge; load bus_in=0 -> IDLE, count=0, timeout stays 0.
REQ-033 Load 1; at edge 3 after load (pre==3, terminal tick) assert timer_in with bus_in=7 -> count=7, pre=0, RUN, timeout never asserts.
REQ-034 Load 0xFFFF, run 100 edges, pulse reset mid-cycle asynchronously -> outputs zero immediately without clock; no counting after release until reload.
REQ-035 PRESCALE=1, load 2 -> timeout=1 after the second unprivileged edge after load.

Source files
------------

// File: rtl/interval_timer.sv
// Preemptive-scheduling interval timer: a loadable down-counter with a prescaler.
// It pauses while in supervisor mode and holds timeout until the next reload.
module interval_timer #(
  parameter int DATA_WIDTH = 16,
  parameter int PRESCALE   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  timer_in,
  input  logic                  privileged,
  output logic                  timeout,
  output logic                  running,
  output logic [DATA_WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  state_t                state;
  state_t                state_next;
  logic [7:0]            pre;
  logic [7:0]            pre_next;
  logic [DATA_WIDTH-1:0] count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pre     <= '0;
      timeout <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      pre     <= pre_next;
      // Flags decode the next state so they line up with the state register.
      timeout <= (state_next == EXPIRED);
      running <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state;
    pre_next   = pre;
    count_next = count;
    if (timer_in) begin
      // A zero load value disarms the timer instead of arming it.
      pre_next = '0;
      if (bus_in != '0) begin
        state_next = RUN;
        count_next = bus_in;
      end else begin
        state_next = IDLE;
        count_next = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          pre_next   = '0;
          count_next = '0;
        end
        RUN: begin
          if (!privileged) begin
            if (pre == PRE_LAST) begin
              pre_next = '0;
              // Guard against wrap: a terminal tick at 1 (or a stray 0) expires.
              if (count <= DATA_WIDTH'(1)) begin
                count_next = '0;
                state_next = EXPIRED;
              end else begin
                count_next = count - DATA_WIDTH'(1);
              end
            end else begin
              pre_next = pre + 8'd1;
            end
          end
        end
        EXPIRED: begin
          pre_next   = '0;
          count_next = '0;
        end
        default: begin
          state_next = IDLE;
          pre_next   = '0;
          count_next = '0;
        end
      endcase
    end
  end

endmodule
